scan_sequencer: RTL

SCAN_SEQUENCER -- requirements
Module: scan_sequencer

---
 rtl/scan_sequencer_pkg.sv | 16 +
 rtl/scan_sequencer_if.sv | 16 +
 rtl/scan_sequencer_next.sv | 43 ++++
 rtl/scan_sequencer.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/scan_sequencer_pkg.sv
// Shared types and constants for the scan sequencer: FSM state encoding,
// direction codes and the default dwell-counter width.
package scan_pkg;

    localparam int DWELL_W_DEF = 8;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_STEP_IDLE = 2'd1,
        ST_STEP_ACK  = 2'd2
    } scan_state_e;

endpackage

// File: rtl/scan_sequencer_if.sv
// Step handshake and select-output bundle of the scan sequencer.
//
// Handshake: 4-phase level protocol. The master raises step_req and holds it
// until it sees step_ack=1; it then drops step_req, and the slave drops
// step_ack on the following edge. Exactly one advance happens per request.
// sel is the registered position code (sel[1] -> decoder a, sel[0] -> b);
// adv is high for the single cycle in which a newly advanced sel is visible.
interface scan_sequencer_if;
    logic       step_req;
    logic       step_ack;
    logic [1:0] sel;
    logic       adv;

    modport master (output step_req, input step_ack, input sel, input adv);
    modport slave  (input step_req, output step_ack, output sel, output adv);
endinterface

// File: rtl/scan_sequencer_next.sv
// Combinational next-position finder: looks at most three positions ahead of
// cur_i in direction dir_i and returns the first one whose mask bit is set.
// found_o=0 means no other enabled position exists; next_o then equals cur_i.
module scan_next
    import scan_pkg::*;
(
    input  logic [1:0] cur_i,
    input  logic       dir_i,
    input  logic [3:0] mask_i,
    output logic [1:0] next_o,
    output logic       found_o
);

    logic [1:0] step;
    logic [1:0] cand1;
    logic [1:0] cand2;
    logic [1:0] cand3;

    // Candidate positions in search order; 2-bit arithmetic gives the wrap.
    always_comb begin
        step  = (dir_i == DIR_DOWN) ? 2'd3 : 2'd1;
        cand1 = cur_i + step;
        cand2 = cur_i + 2'd2;
        cand3 = cur_i - step;
    end

    // Priority pick of the nearest enabled candidate.
    always_comb begin
        next_o  = cur_i;
        found_o = 1'b0;
        if (mask_i[cand1]) begin
            next_o  = cand1;
            found_o = 1'b1;
        end else if (mask_i[cand2]) begin
            next_o  = cand2;
            found_o = 1'b1;
        end else if (mask_i[cand3]) begin
            next_o  = cand3;
            found_o = 1'b1;
        end
    end

endmodule

// File: rtl/scan_sequencer.sv
// Scan sequencer top: walks a 2-bit select code through positions 0..3,
// either free-running with a programmable dwell or one step per handshake.
// Optional feature macro: SCAN_MASK_EN adds a per-position mask input; when
// undefined all four positions are always enabled.
module scan_sequencer
    import scan_pkg::*;
#(
    parameter int DWELL_W = DWELL_W_DEF
)(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               mode,
    input  logic               dir,
    input  logic [DWELL_W-1:0] dwell,
    input  logic               load,
    input  logic [1:0]         load_val,
`ifdef SCAN_MASK_EN
    input  logic [3:0]         mask,
`endif
    scan_sequencer_if.slave    bus,
    output scan_state_e        state_o
);

    localparam logic [DWELL_W-1:0] CNT_ONE = {{(DWELL_W-1){1'b0}}, 1'b1};

    scan_state_e        state_q, state_d;
    logic [1:0]         sel_q, sel_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic               adv_q, adv_d;
    logic               ack_q, ack_d;
    // A request is only accepted after step_req has been seen low since the
    // last accept or reset, so a request left high across reset is ignored.
    logic               armed_q, armed_d;
    logic               accept;

    logic [3:0]         mask_eff;
    logic [1:0]         nxt;
    logic               nxt_found;

`ifdef SCAN_MASK_EN
    assign mask_eff = mask;
`else
    assign mask_eff = 4'hF;
`endif

    scan_next u_next (
        .cur_i   (sel_q),
        .dir_i   (dir),
        .mask_i  (mask_eff),
        .next_o  (nxt),
        .found_o (nxt_found)
    );

    // State, position, dwell counter and handshake registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            sel_q   <= 2'd0;
            cnt_q   <= '0;
            adv_q   <= 1'b0;
            ack_q   <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            adv_q   <= adv_d;
            ack_q   <= ack_d;
            armed_q <= armed_d;
        end
    end

    // Next-state logic: mode switches first, then per-state behaviour, and a
    // load overrides whatever position/counter change the state chose.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        adv_d   = 1'b0;
        ack_d   = ack_q;
        armed_d = armed_q;
        accept  = 1'b0;

        case (state_q)
            ST_RUN: begin
                ack_d = 1'b0;
                if (mode) begin
                    state_d = ST_STEP_IDLE;
                    cnt_d   = '0;
                end else if (en) begin
                    if (cnt_q == dwell) begin
                        cnt_d = '0;
                        if (nxt_found) begin
                            sel_d = nxt;
                            adv_d = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            end
            ST_STEP_IDLE: begin
                cnt_d = '0;
                if (!mode) begin
                    state_d = ST_RUN;
                    ack_d   = 1'b0;
                end else if (bus.step_req && en && armed_q) begin
                    accept  = 1'b1;
                    ack_d   = 1'b1;
                    state_d = ST_STEP_ACK;
                    if (nxt_found) begin
                        sel_d = nxt;
                        adv_d = 1'b1;
                    end
                end
            end
            ST_STEP_ACK: begin
                cnt_d = '0;
                if (!mode) begin
                    state_d = ST_RUN;
                    ack_d   = 1'b0;
                end else if (!bus.step_req) begin
                    state_d = ST_STEP_IDLE;
                    ack_d   = 1'b0;
                end
            end
            default: begin
                state_d = ST_RUN;
                cnt_d   = '0;
                ack_d   = 1'b0;
            end
        endcase

        if (!bus.step_req) begin
            armed_d = 1'b1;
        end else if (accept) begin
            armed_d = 1'b0;
        end

        if (load) begin
            sel_d = load_val;
            cnt_d = '0;
            adv_d = 1'b0;
        end
    end

    assign bus.sel      = sel_q;
    assign bus.adv      = adv_q;
    assign bus.step_ack = ack_q;
    assign state_o      = state_q;

endmodule
